// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan driver: character codes,
// active-low segment patterns ({g,f,e,d,c,b,a}) and the blink phase type.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 5;
  localparam int SEG_W      = 7;

  typedef logic [CODE_W-1:0] char_code_t;
  typedef logic [SEG_W-1:0]  seg_t;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_t;

  localparam char_code_t CH_BLANK = 5'h10;
  localparam char_code_t CH_DASH  = 5'h11;
  localparam char_code_t CH_P     = 5'h12;
  localparam char_code_t CH_R     = 5'h13;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_P     = 7'h0C;
  localparam seg_t SEG_R     = 7'h2F;

  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

  // Active-low one-hot anode select for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational character-code to active-low segment pattern decoder.
// Unassigned codes fall through to blank.
module seg_decoder
  import display_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00:   seg = SEG_0;
      5'h01:   seg = SEG_1;
      5'h02:   seg = SEG_2;
      5'h03:   seg = SEG_3;
      5'h04:   seg = SEG_4;
      5'h05:   seg = SEG_5;
      5'h06:   seg = SEG_6;
      5'h07:   seg = SEG_7;
      5'h08:   seg = SEG_8;
      5'h09:   seg = SEG_9;
      5'h0A:   seg = SEG_A;
      5'h0B:   seg = SEG_B;
      5'h0C:   seg = SEG_C;
      5'h0D:   seg = SEG_D;
      5'h0E:   seg = SEG_E;
      5'h0F:   seg = SEG_F;
      CH_DASH: seg = SEG_DASH;
      CH_P:    seg = SEG_P;
      CH_R:    seg = SEG_R;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed 8-digit common-anode scan driver with double-buffered character
// storage, anti-ghost blanking at each slot start and global hardware blink.
module seven_seg_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NUM_DIGITS*CODE_W-1:0] chars,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic                         enable,
  output logic                         ready,
  output logic                         frame_tick,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [SEG_W-1:0]             digit
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] char_buf_t;

  logic [CW-1:0]           cnt_q,          cnt_d;
  logic [2:0]              idx_q,          idx_d;
  logic [BW-1:0]           blink_cnt_q,    blink_cnt_d;
  blink_phase_t            phase_q,        phase_d;
  char_buf_t               active_chars_q, active_chars_d;
  logic [NUM_DIGITS-1:0]   active_mask_q,  active_mask_d;
  char_buf_t               shadow_chars_q, shadow_chars_d;
  logic [NUM_DIGITS-1:0]   shadow_mask_q,  shadow_mask_d;
  logic                    pending_q,      pending_d;
  logic                    ready_q,        ready_d;
  logic                    frame_tick_q,   frame_tick_d;
  logic [NUM_DIGITS-1:0]   an_q,           an_d;
  logic [SEG_W-1:0]        digit_q,        digit_d;

  logic                    cnt_wrap;
  logic                    frame_end;
  logic [CODE_W-1:0]       sel_char;
  logic [SEG_W-1:0]        sel_seg;

  assign sel_char = active_chars_q[idx_q];

  seg_decoder u_seg_decoder (
    .code (sel_char),
    .seg  (sel_seg)
  );

  always_comb begin
    cnt_wrap       = (cnt_q == CNT_MAX);
    frame_end      = cnt_wrap && (idx_q == 3'd7);

    cnt_d          = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d          = cnt_wrap ? idx_q + 3'd1 : idx_q;

    blink_cnt_d    = blink_cnt_q + BW'(1);
    phase_d        = phase_q;
    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
    end

    // Commit reads the pre-edge shadow, so a load on the boundary waits a frame.
    active_chars_d = active_chars_q;
    active_mask_d  = active_mask_q;
    shadow_chars_d = shadow_chars_q;
    shadow_mask_d  = shadow_mask_q;
    pending_d      = pending_q;
    if (frame_end && pending_q) begin
      active_chars_d = shadow_chars_q;
      active_mask_d  = shadow_mask_q;
      pending_d      = 1'b0;
    end
    if (load) begin
      shadow_chars_d = chars;
      shadow_mask_d  = blink_mask;
      pending_d      = 1'b1;
    end

    ready_d        = ~pending_d;
    frame_tick_d   = frame_end;

    an_d           = AN_ALL_OFF;
    if (enable && (cnt_q >= CNT_BLANK)) begin
      an_d = anode_sel_n(idx_q);
    end

    digit_d        = sel_seg;
    if (active_mask_q[idx_q] && (phase_q == PHASE_HIDDEN)) begin
      digit_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      phase_q        <= PHASE_VISIBLE;
      active_chars_q <= {NUM_DIGITS{CH_BLANK}};
      active_mask_q  <= '0;
      shadow_chars_q <= {NUM_DIGITS{CH_BLANK}};
      shadow_mask_q  <= '0;
      pending_q      <= 1'b0;
      ready_q        <= 1'b1;
      frame_tick_q   <= 1'b0;
      an_q           <= AN_ALL_OFF;
      digit_q        <= SEG_BLANK;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      active_chars_q <= active_chars_d;
      active_mask_q  <= active_mask_d;
      shadow_chars_q <= shadow_chars_d;
      shadow_mask_q  <= shadow_mask_d;
      pending_q      <= pending_d;
      ready_q        <= ready_d;
      frame_tick_q   <= frame_tick_d;
      an_q           <= an_d;
      digit_q        <= digit_d;
    end
  end

  assign ready      = ready_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign digit      = digit_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus a random soak,
// compared every cycle against a frame-arithmetic reference model.
module tb_seven_seg_scan;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int BK    = 64;
  localparam int FRAME = RD * 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [39:0] chars;
  logic [7:0]  blink_mask;
  logic        enable;
  logic        ready;
  logic        frame_tick;
  logic [7:0]  an;
  logic [6:0]  digit;

  int checks   = 0;
  int failures = 0;

  // Reference model state; n is the index of the next edge since reset release.
  int          n;
  logic [4:0]  m_shadow [8];
  logic [4:0]  m_active [8];
  logic [7:0]  m_smask;
  logic [7:0]  m_amask;
  bit          m_pending;
  logic [7:0]  exp_an;
  logic [6:0]  exp_digit;
  logic        exp_ready;
  logic        exp_tick;
  logic [6:0]  seg_tab [32];

  always #5 clock = ~clock;

  seven_seg_scan #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_CYCLES (BK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .chars      (chars),
    .blink_mask (blink_mask),
    .enable     (enable),
    .ready      (ready),
    .frame_tick (frame_tick),
    .an         (an),
    .digit      (digit)
  );

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = 5'h10;
      m_active[k] = 5'h10;
    end
    m_smask   = 8'h00;
    m_amask   = 8'h00;
    m_pending = 1'b0;
    n         = 0;
    exp_an    = 8'hFF;
    exp_digit = 7'h7F;
    exp_ready = 1'b1;
    exp_tick  = 1'b0;
  endtask

  task automatic check_output();
    checks++;
    assert (an === exp_an) else begin
      failures++;
      $error("FAIL an edge=%0d got=%h exp=%h", n, an, exp_an);
    end
    checks++;
    assert (digit === exp_digit) else begin
      failures++;
      $error("FAIL digit edge=%0d got=%h exp=%h", n, digit, exp_digit);
    end
    checks++;
    assert (ready === exp_ready) else begin
      failures++;
      $error("FAIL ready edge=%0d got=%b exp=%b", n, ready, exp_ready);
    end
    checks++;
    assert (frame_tick === exp_tick) else begin
      failures++;
      $error("FAIL frame_tick edge=%0d got=%b exp=%b", n, frame_tick, exp_tick);
    end
  endtask

  // One clock: predict the outputs produced by this edge, then check them.
  task automatic step();
    int idx;
    bit hidden;
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      idx       = (n / RD) % 8;
      hidden    = ((n / BK) % 2) == 1;
      exp_an    = (!enable || (n % RD) < BC) ? 8'hFF : ~(8'h01 << idx);
      exp_digit = (m_amask[idx] && hidden) ? 7'h7F : seg_tab[m_active[idx]];
      exp_tick  = (n % FRAME) == FRAME - 1;
      if (exp_tick && m_pending) begin
        for (int k = 0; k < 8; k++) m_active[k] = m_shadow[k];
        m_amask   = m_smask;
        m_pending = 1'b0;
      end
      if (load) begin
        for (int k = 0; k < 8; k++) m_shadow[k] = chars[5*k +: 5];
        m_smask   = blink_mask;
        m_pending = 1'b1;
      end
      exp_ready = !m_pending;
      n++;
    end
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [39:0] c, input logic [7:0] m);
    chars      = c;
    blink_mask = m;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic advance_to(input int phase);
    for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) step();
  endtask

  function automatic logic [39:0] rand_chars();
    logic [39:0] c;
    c[31:0]  = $urandom;
    c[39:32] = 8'($urandom);
    return c;
  endfunction

  initial begin
    logic [39:0] c;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                7'h7F, 7'h3F, 7'h0C, 7'h2F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    model_reset();
    reset      = 1'b0;
    load       = 1'b0;
    enable     = 1'b1;
    chars      = {8{5'h10}};
    blink_mask = 8'h00;

    // Reset and idle scan over two frames.
    repeat (3) step();
    reset = 1'b1;
    repeat (130) step();

    // Hex 0..7 in digits 0..7.
    for (int k = 0; k < 8; k++) c[5*k +: 5] = 5'(k);
    apply_stimulus(c, 8'h00);
    repeat (140) step();

    // Two loads in one frame: only the second is ever shown.
    advance_to(4);
    apply_stimulus(rand_chars(), 8'h00);
    repeat (5) step();
    apply_stimulus(rand_chars(), 8'h00);
    repeat (140) step();

    // Load on the boundary cycle while a previous load is pending.
    advance_to(10);
    apply_stimulus(rand_chars(), 8'h00);
    advance_to(FRAME - 1);
    apply_stimulus(rand_chars(), 8'h00);
    repeat (140) step();

    // Blink digit 0 showing 'b'.
    c = rand_chars();
    c[4:0] = 5'h0B;
    apply_stimulus(c, 8'h01);
    repeat (300) step();

    // Disable for 20 cycles, then reset mid-slot.
    enable = 1'b0;
    repeat (20) step();
    for (int i = 0; i < RD && (n % RD) != 4; i++) step();
    reset  = 1'b0;
    enable = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    repeat (70) step();

    // Random soak: sporadic loads, masks and enable drops.
    repeat (600) begin
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        chars      = rand_chars();
        blink_mask = 8'($urandom);
      end
      enable = ($urandom_range(0, 9) != 0);
      step();
    end
    load = 1'b0;
    enable = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
